// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the CowCat32 5-stage pipeline (load-use, branch, memory wait).
// Define PERF_CNT_EN to add the stall_cycles performance counter port.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] inst_ID,
  input  logic [9:0]  inst_EX,
  input  logic        br_taken_EX,
  input  logic        mem_req_MA,
  input  logic        mem_ack,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MA,
  output logic        flush_ID,
  output logic        bubble_EX,
  output logic        bubble_WB,
  output logic        mem_timeout
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [4:0] OP_R    = 5'b01100;
  localparam logic [4:0] OP_I    = 5'b00100;
  localparam logic [4:0] OP_L    = 5'b00000;
  localparam logic [4:0] OP_S    = 5'b01000;
  localparam logic [4:0] OP_B    = 5'b11000;
  localparam logic [4:0] OP_JALR = 5'b11001;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("hazard_ctrl: TIMEOUT must lie in 2..65535");
  end

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_ABORT
  } state_t;

  function automatic logic uses_rs1(input logic [4:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_L) ||
           (op == OP_S) || (op == OP_B) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B);
  endfunction

  logic [4:0]  id_op;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        lu;
  logic        ms;
  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nxt;
  logic [16:0] wait_inc;

  assign id_op  = inst_ID[4:0];
  assign id_rs1 = inst_ID[9:5];
  assign id_rs2 = inst_ID[14:10];
  assign ex_op  = inst_EX[4:0];
  assign ex_rd  = inst_EX[9:5];

  assign lu = (ex_op == OP_L) && (ex_rd != 5'd0) &&
              ((uses_rs1(id_op) && (id_rs1 == ex_rd)) ||
               (uses_rs2(id_op) && (id_rs2 == ex_rd)));

  assign wait_inc = {1'b0, wait_cnt} + 17'd1;

  // Next-state: the wait counter equals the number of stalled cycles seen so far
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ms           = 1'b0;
    unique case (state)
      ST_RUN: begin
        ms = mem_req_MA & ~mem_ack;
        if (ms) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        ms = ~mem_ack;
        if (mem_ack) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 16'd0;
        end else if (wait_inc == TIMEOUT_L) begin
          state_nxt    = ST_ABORT;
          wait_cnt_nxt = 16'd0;
        end else begin
          wait_cnt_nxt = wait_inc[15:0];
        end
      end
      ST_ABORT: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Output priority: memory stall > taken branch > load-use; all forced low in reset
  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MA  = 1'b0;
    flush_ID  = 1'b0;
    bubble_EX = 1'b0;
    bubble_WB = 1'b0;
    if (rst_n) begin
      if (ms) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        stall_EX  = 1'b1;
        stall_MA  = 1'b1;
        bubble_WB = 1'b1;
      end else if (br_taken_EX) begin
        flush_ID  = 1'b1;
        bubble_EX = 1'b1;
      end else if (lu) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        bubble_EX = 1'b1;
      end
    end
  end

  assign mem_timeout = rst_n && (state == ST_ABORT);

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
    end else if (stall_IF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller for the CowCat32 5-stage core. It works alongside the forwarding unit and resolves the hazards that forwarding cannot: load-use dependencies, taken-branch redirects and multi-cycle data-memory accesses. It drives hold and bubble controls for the IF/ID, ID/EX, EX/MA and MA/WB pipeline registers. It also aborts memory accesses that exceed a cycle budget.

## Interface
- TIMEOUT, 255: maximum stalled cycles allowed for one memory access; legal range 2..65535.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- inst_ID  input  15  instruction in ID, packed {rs2[14:10], rs1[9:5], opcode[4:0]}; opcode is inst[6:2].
- inst_EX  input  10  instruction in EX, packed {rd[9:5], opcode[4:0]}.
- br_taken_EX  input  1  branch or jump in EX resolved taken this cycle.
- mem_req_MA  input  1  instruction in MA is a load or store that needs data memory.
- mem_ack  input  1  data memory completes the MA access this cycle.
- stall_IF, stall_ID, stall_EX, stall_MA  output  1 each  hold PC, IF/ID, ID/EX and EX/MA respectively.
- flush_ID  output  1  load a NOP into IF/ID.
- bubble_EX  output  1  load a NOP into ID/EX.
- bubble_WB  output  1  load a NOP into MA/WB.
- mem_timeout  output  1  one-cycle pulse: the memory access was aborted.
- stall_cycles  output  32  present only with PERF_CNT_EN.

## Operation
- Opcodes: Rtype 01100, Itype 00100, Ltype 00000, Stype 01000, Btype 11000, JALR 11001.
- Load-use hazard (lu):
  - Condition: EX opcode is Ltype, EX rd is nonzero, and ID uses that register.
  - rs1 is a use for Rtype, Itype, Ltype, Stype, Btype and JALR.
  - rs2 is a use for Rtype, Stype and Btype.
- Memory stall (ms):
  - In RUN: mem_req_MA & !mem_ack.
  - In MEM_WAIT: !mem_ack.
  - In ABORT: always 0.
- FSM states RUN, MEM_WAIT, ABORT. Transitions:
  - RUN → MEM_WAIT when ms.
  - MEM_WAIT → RUN on mem_ack.
  - MEM_WAIT → ABORT when !mem_ack and the stalled-cycle count reaches TIMEOUT.
  - ABORT → RUN unconditionally.
- Wait counter:
  - Set to 1 in the RUN cycle that raises ms.
  - Increments on each MEM_WAIT cycle without mem_ack.
  - The transition to ABORT happens on the MEM_WAIT cycle where count+1 == TIMEOUT.
  - Result: exactly TIMEOUT stalled cycles precede ABORT.
- Output priority, evaluated combinationally every cycle:
  1. If ms: stall_IF, stall_ID, stall_EX, stall_MA and bubble_WB are 1; flush_ID and bubble_EX are 0.
  2. Else if br_taken_EX: flush_ID and bubble_EX are 1; all stalls are 0. A taken branch overrides load-use, because the ID instruction is squashed.
  3. Else if lu: stall_IF, stall_ID and bubble_EX are 1.
  4. Else all controls are 0.
- A cycle with mem_ack in MEM_WAIT, or any ABORT cycle, is an advance cycle. Branch and load-use rules apply normally in that cycle.
- mem_ack in ABORT or RUN without a request is ignored.
- mem_timeout = (state == ABORT).

## Timing
- Hazard outputs are combinational in the same cycle.
- State, wait counter and mem_timeout are registered on the clk rising edge.
- The load-use bubble lasts exactly 1 cycle. Afterwards the load is in MA, so the hazard condition clears by itself.
- A branch flush lasts 1 cycle.
- A memory stall lasts from the request cycle up to, but not including, the mem_ack cycle.
- Reset:
  - rst_n low forces state RUN and counter 0 immediately.
  - All outputs are forced to 0 while rst_n is low, including mid-stall.
  - After release, the first cycle is evaluated as RUN.
- A br_taken_EX raised during MEM_WAIT is held in EX by stall_EX. It takes effect in the advance cycle.

## Configuration
- PERF_CNT_EN defined:
  - stall_cycles is a 32-bit register.
  - It increments on every cycle where stall_IF is 1 and wraps 0xFFFFFFFF → 0.
  - It resets to 0.
- PERF_CNT_EN undefined: the stall_cycles port and its logic are absent. No other behaviour changes.

## Test plan
- Load-use: EX = lw x5 (rd 5, opcode 00000), ID = add with rs2 = 5 → stall_IF, stall_ID and bubble_EX are 1 for one cycle; with rd = 0 → all 0.
- Branch vs load-use: same load-use case plus br_taken_EX = 1 → flush_ID = 1, bubble_EX = 1, stall_IF = 0.
- Memory wait: mem_req_MA held high, mem_ack on the 3rd cycle → stalls high for cycles 1–2, low on cycle 3, state back to RUN, mem_timeout stays 0.
- Timeout with TIMEOUT = 4, no mem_ack:
  - Stalls high for 4 cycles.
  - 5th cycle: mem_timeout = 1 and stalls 0.
  - 6th cycle: RUN, and a still-high mem_req_MA re-enters MEM_WAIT.
- Reset mid-stall: rst_n pulled low in MEM_WAIT → all outputs 0 asynchronously; after release, mem_req_MA = 0 → RUN with idle outputs.
- PERF_CNT_EN: 3 load-use cycles plus 5 memory-stall cycles → stall_cycles = 8; counter preloaded to 0xFFFFFFFF plus one stall → 0.
